eb_fifo_ctrl: RTL and testbench



---
 rtl/eb_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_eb_fifo_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/eb_fifo_ctrl.sv
// eb_fifo_ctrl: parametrised elastic buffer (req/ack on both sides) with
// DEPTH x WIDTH storage, registered handshake outputs and occupancy count.
// Optional macro EB_FIFO_BYPASS_EN: combinational cut-through while EMPTY.
module eb_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             t_0_req,
    output logic             t_0_ack,
    input  logic [WIDTH-1:0] t_0_data,
    output logic             i_0_req,
    input  logic             i_0_ack,
    output logic [WIDTH-1:0] i_0_data,
    output logic [CNTW-1:0]  count
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MID   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNTW-1:0]   count_nxt;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              rd_en;
    logic              bypass;

    // Handshake outputs, storage enables, next count and next state.
    always_comb begin
        t_0_ack   = (state != FULL);
`ifdef EB_FIFO_BYPASS_EN
        bypass    = (state == EMPTY);
        i_0_req   = bypass ? t_0_req : 1'b1;
`else
        bypass    = 1'b0;
        i_0_req   = (state != EMPTY);
`endif
        push      = t_0_req & t_0_ack;
        pop       = i_0_req & i_0_ack;
        // A word taken straight through while EMPTY is never written.
        wr_en     = push & ~(bypass & pop);
        rd_en     = pop & ~bypass;
        count_nxt = count;
        state_nxt = state;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CNTW'(1);
            2'b01:   count_nxt = count - CNTW'(1);
            default: count_nxt = count;
        endcase
        case (state)
            EMPTY: if (wr_en) state_nxt = MID;
            MID: begin
                if (wr_en && !rd_en && count == CNTW'(DEPTH - 1))
                    state_nxt = FULL;
                else if (rd_en && !wr_en && count == CNTW'(1))
                    state_nxt = EMPTY;
            end
            FULL:    if (rd_en) state_nxt = MID;
            default: state_nxt = EMPTY;
        endcase
    end

    // Control registers: state, occupancy and wrapping pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (wr_en)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (rd_en)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= t_0_data;
    end

`ifdef EB_FIFO_BYPASS_EN
    assign i_0_data = bypass ? t_0_data : mem[rd_ptr];
`else
    assign i_0_data = mem[rd_ptr];
`endif

endmodule

// File: tb/tb_eb_fifo_ctrl.sv
// tb_eb_fifo_ctrl: self-checking bench for eb_fifo_ctrl; a DEPTH=4 and a
// DEPTH=3 instance are compared every cycle against a queue reference model.
module tb_eb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;

    logic       a_treq, a_tack, a_ireq, a_iack;
    logic [7:0] a_tdata, a_idata;
    logic [2:0] a_cnt;

    logic       b_treq, b_tack, b_ireq, b_iack;
    logic [7:0] b_tdata, b_idata;
    logic [1:0] b_cnt;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    int checks   = 0;
    int failures = 0;
    int pops_a   = 0;
    int pushed_b = 0;

    always #5 clk = ~clk;

    eb_fifo_ctrl #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .t_0_req(a_treq), .t_0_ack(a_tack), .t_0_data(a_tdata),
        .i_0_req(a_ireq), .i_0_ack(a_iack), .i_0_data(a_idata),
        .count(a_cnt)
    );

    eb_fifo_ctrl #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .t_0_req(b_treq), .t_0_ack(b_tack), .t_0_data(b_tdata),
        .i_0_req(b_ireq), .i_0_ack(b_iack), .i_0_data(b_idata),
        .count(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected behaviour of one buffer given its stored words and inputs.
    task automatic check_side(input string tag, input int depth, input int size,
                              input logic [7:0] head, input logic treq,
                              input logic [7:0] tdata, input logic iack,
                              input logic dack, input logic dreq,
                              input logic [7:0] ddata, input int dcnt,
                              output logic push, output logic pop);
        logic       exp_req;
        logic [7:0] exp_data;
        exp_req  = (size > 0);
        exp_data = head;
`ifdef EB_FIFO_BYPASS_EN
        if (size == 0) begin
            exp_req  = treq;
            exp_data = tdata;
        end
`endif
        chk({tag, "_t_0_ack"}, 32'(dack), 32'(size < depth));
        chk({tag, "_i_0_req"}, 32'(dreq), 32'(exp_req));
        chk({tag, "_count"}, 32'(dcnt), 32'(size));
        if (exp_req)
            chk({tag, "_i_0_data"}, 32'(ddata), 32'(exp_data));
        push = treq && (size < depth);
        pop  = exp_req && iack;
    endtask

    // One clock cycle: inputs already applied, check mid-cycle, update model.
    task automatic step();
        logic pa, oa, pb, ob;
        check_side("a", 4, qa.size(), (qa.size() > 0) ? qa[0] : 8'h00,
                   a_treq, a_tdata, a_iack, a_tack, a_ireq, a_idata, int'(a_cnt), pa, oa);
        check_side("b", 3, qb.size(), (qb.size() > 0) ? qb[0] : 8'h00,
                   b_treq, b_tdata, b_iack, b_tack, b_ireq, b_idata, int'(b_cnt), pb, ob);
        @(posedge clk);
        #1;
        if (oa) pops_a++;
        if (pb) pushed_b++;
        if (!(qa.size() == 0 && pa && oa)) begin
            if (oa) void'(qa.pop_front());
            if (pa) qa.push_back(a_tdata);
        end
        if (!(qb.size() == 0 && pb && ob)) begin
            if (ob) void'(qb.pop_front());
            if (pb) qb.push_back(b_tdata);
        end
    endtask

    task automatic drive_a(input logic req, input logic [7:0] data, input logic ack);
        a_treq = req; a_tdata = data; a_iack = ack;
        @(negedge clk);
        step();
    endtask

    initial begin
        int cyc;
        int pops_stream;
        reset_n = 1'b0;
        a_treq = 1'b0; a_tdata = '0; a_iack = 1'b0;
        b_treq = 1'b0; b_tdata = '0; b_iack = 1'b0;
        #3;
        chk("reset_t_0_ack", 32'(a_tack), 32'd1);
        chk("reset_i_0_req", 32'(a_ireq), 32'd0);
        chk("reset_count", 32'(a_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle cycles.
        repeat (2) drive_a(1'b0, 8'h00, 1'b0);

        // Async reset with three stored words.
        for (int i = 0; i < 3; i++) drive_a(1'b1, 8'(8'h61 + i), 1'b0);
        chk("pre_reset_count", 32'(a_cnt), 32'd3);
        a_treq = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(a_cnt), 32'd0);
        chk("async_rst_i_0_req", 32'(a_ireq), 32'd0);
        chk("async_rst_t_0_ack", 32'(a_tack), 32'd1);
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Fill to FULL, 5th word refused, then drain in order.
        for (int i = 0; i < 4; i++) drive_a(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        chk("full_count", 32'(a_cnt), 32'd4);
        chk("full_t_0_ack", 32'(a_tack), 32'd0);
        drive_a(1'b1, 8'h55, 1'b0);
        chk("fifth_refused_count", 32'(a_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("drain_order", 32'(a_idata), 32'(8'h11 * (i + 1)));
            drive_a(1'b0, 8'h00, 1'b1);
        end
        chk("drained_count", 32'(a_cnt), 32'd0);

        // FULL with req and ack together: only the pop happens.
        for (int i = 0; i < 4; i++) drive_a(1'b1, 8'(8'hC0 + i), 1'b0);
        drive_a(1'b1, 8'hEE, 1'b1);
        chk("full_pop_count", 32'(a_cnt), 32'd3);
        chk("full_pop_t_0_ack", 32'(a_tack), 32'd1);
        for (int i = 0; i < 3; i++) drive_a(1'b0, 8'h00, 1'b1);

        // Streaming: 100 incrementing words, req and ack held high.
        pops_a = 0;
        for (int i = 0; i < 100; i++) drive_a(1'b1, 8'(i), 1'b1);
        pops_stream = pops_a;
`ifdef EB_FIFO_BYPASS_EN
        chk("stream_pops", 32'(pops_stream), 32'd100);
`else
        chk("stream_pops", 32'(pops_stream), 32'd99);
        chk("stream_count", 32'(a_cnt), 32'd1);
`endif
        for (int i = 0; i < 2; i++) drive_a(1'b0, 8'h00, 1'b1);
        chk("stream_total_pops", 32'(pops_a), 32'd100);

        // First-word latency from EMPTY with ack already high.
        a_treq = 1'b1; a_tdata = 8'hA5; a_iack = 1'b1;
        #3;
`ifdef EB_FIFO_BYPASS_EN
        chk("bypass_same_cycle_req", 32'(a_ireq), 32'd1);
        chk("bypass_same_cycle_data", 32'(a_idata), 32'hA5);
`else
        chk("latency_same_cycle_req", 32'(a_ireq), 32'd0);
`endif
        @(negedge clk);
        step();
        a_treq = 1'b0;
        #3;
`ifdef EB_FIFO_BYPASS_EN
        chk("bypass_count_after", 32'(a_cnt), 32'd0);
`else
        chk("latency_next_cycle_req", 32'(a_ireq), 32'd1);
        chk("latency_next_cycle_data", 32'(a_idata), 32'hA5);
`endif
        drive_a(1'b0, 8'h00, 1'b1);
        a_iack = 1'b0;

        // Random traffic on the DEPTH=3 buffer until 1000 words accepted.
        pushed_b = 0;
        cyc = 0;
        while (pushed_b < 1000 && cyc < 20000) begin
            b_treq  = 1'($urandom_range(0, 1));
            b_tdata = 8'($urandom);
            b_iack  = 1'($urandom_range(0, 1));
            @(negedge clk);
            step();
            cyc++;
        end
        chk("random_words_accepted", 32'(pushed_b), 32'd1000);
        b_treq = 1'b0;
        b_iack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            step();
        end
        chk("random_drained_count", 32'(b_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
